// File: rtl/tx_word_serializer.sv
// tx_word_serializer
// Pops one WORD_W-bit word from the upstream FIFO and sends it to the UART
// transmitter as WORD_W/BYTE_W bytes. Each byte goes out with a tx_start
// pulse, and the next byte waits for tx_done. The byte order is latched per
// word. busy and frame_done report status.
// Optional trailing XOR checksum byte: define TX_WORD_SERIALIZER_CHECKSUM_EN.
//
// state     | meaning
// IDLE      | waiting for a word; pops the FIFO when it is not empty
// LOAD      | capture FIFO data and byte order, clear byte counter
// SEND      | present head byte on d_out with tx_start, shift register
// WAIT      | hold d_out until the UART reports tx_done
// CSUM      | present XOR checksum byte with tx_start (checksum build)
// WAIT_CSUM | wait for tx_done of the checksum byte (checksum build)
// DONE      | frame_done is high this cycle; return to IDLE
//
// The d_in capture relies on the FIFO still presenting the popped word in
// the LOAD cycle. This holds for a show-ahead FIFO whose pop takes effect
// at the end of the buffer_read cycle.
// frame_done is registered on the WAIT->DONE transition. This makes it
// coincide with the DONE state, one cycle after the last tx_done.

module tx_word_serializer #(
    parameter int WORD_W = 128,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] d_in,
    input  logic              buffer_empty,
    output logic              buffer_read,
    input  logic              msb_first,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [BYTE_W-1:0] d_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int NBYTES = WORD_W / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

`ifdef TX_WORD_SERIALIZER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT, S_DONE, S_CSUM, S_WAIT_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT, S_DONE
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_sreg;
    logic [WORD_W-1:0]   w_sreg_nxt;
    logic                r_order;
    logic                w_order_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [BYTE_W-1:0]   r_d_out;
    logic [BYTE_W-1:0]   w_d_out_nxt;
    logic                r_tx_start;
    logic                w_tx_start_nxt;
    logic                r_buffer_read;
    logic                w_buffer_read_nxt;
    logic                r_frame_done;
    logic                w_frame_done_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic [BYTE_W-1:0]   w_head;
`ifdef TX_WORD_SERIALIZER_CHECKSUM_EN
    logic [BYTE_W-1:0]   r_acc;
    logic [BYTE_W-1:0]   w_acc_nxt;
`endif

    assign w_head = r_order ? r_sreg[WORD_W-1 -: BYTE_W] : r_sreg[BYTE_W-1:0];

    // Next-state and next-value logic for every registered output and datapath register.
    always_comb begin
        w_state_nxt       = r_state;
        w_sreg_nxt        = r_sreg;
        w_order_nxt       = r_order;
        w_cnt_nxt         = r_cnt;
        w_d_out_nxt       = r_d_out;
        w_tx_start_nxt    = 1'b0;
        w_buffer_read_nxt = 1'b0;
        w_frame_done_nxt  = 1'b0;
`ifdef TX_WORD_SERIALIZER_CHECKSUM_EN
        w_acc_nxt         = r_acc;
`endif
        case (r_state)
            S_IDLE: begin
                if (!buffer_empty) begin
                    w_buffer_read_nxt = 1'b1;
                    w_state_nxt       = S_LOAD;
                end
            end
            S_LOAD: begin
                w_sreg_nxt  = d_in;
                w_order_nxt = msb_first;
                w_cnt_nxt   = '0;
`ifdef TX_WORD_SERIALIZER_CHECKSUM_EN
                w_acc_nxt   = '0;
`endif
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_d_out_nxt    = w_head;
                w_tx_start_nxt = 1'b1;
                w_sreg_nxt     = r_order ? (r_sreg << BYTE_W) : (r_sreg >> BYTE_W);
`ifdef TX_WORD_SERIALIZER_CHECKSUM_EN
                w_acc_nxt      = r_acc ^ w_head;
`endif
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (r_cnt == LAST_CNT) begin
`ifdef TX_WORD_SERIALIZER_CHECKSUM_EN
                        w_state_nxt      = S_CSUM;
`else
                        w_state_nxt      = S_DONE;
                        w_frame_done_nxt = 1'b1;
`endif
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_state_nxt = S_SEND;
                    end
                end
            end
`ifdef TX_WORD_SERIALIZER_CHECKSUM_EN
            S_CSUM: begin
                w_d_out_nxt    = r_acc;
                w_tx_start_nxt = 1'b1;
                w_state_nxt    = S_WAIT_CSUM;
            end
            S_WAIT_CSUM: begin
                if (tx_done) begin
                    w_state_nxt      = S_DONE;
                    w_frame_done_nxt = 1'b1;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg        <= '0;
            r_order       <= 1'b0;
            r_cnt         <= '0;
            r_d_out       <= '0;
            r_tx_start    <= 1'b0;
            r_buffer_read <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
`ifdef TX_WORD_SERIALIZER_CHECKSUM_EN
            r_acc         <= '0;
`endif
        end else begin
            r_sreg        <= w_sreg_nxt;
            r_order       <= w_order_nxt;
            r_cnt         <= w_cnt_nxt;
            r_d_out       <= w_d_out_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_buffer_read <= w_buffer_read_nxt;
            r_frame_done  <= w_frame_done_nxt;
            r_busy        <= w_busy_nxt;
`ifdef TX_WORD_SERIALIZER_CHECKSUM_EN
            r_acc         <= w_acc_nxt;
`endif
        end
    end

    assign buffer_read = r_buffer_read;
    assign tx_start    = r_tx_start;
    assign d_out       = r_d_out;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_tx_word_serializer.sv
// Testbench for tx_word_serializer. It runs a 32-bit and a 128-bit instance
// one at a time. A show-ahead FIFO model feeds the active instance, and a
// UART responder answers each tx_start with tx_done. A scoreboard monitor
// compares every byte and frame against a reference model.

module tb_tx_word_serializer;

`ifdef TX_WORD_SERIALIZER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   empty = 2'b11;
    logic [1:0]   rd, txs, busy, fd;
    logic         msb = 1'b1;
    logic         txd_resp = 1'b0;
    logic         txd_stim = 1'b0;
    logic         txd;
    logic [31:0]  din0 = '0;
    logic [127:0] din1 = '0;
    logic [7:0]   dout0, dout1;

    always #5 clk = ~clk;
    assign txd = txd_resp | txd_stim;

    tx_word_serializer #(.WORD_W(32), .BYTE_W(8)) dut32 (
        .clk(clk), .reset(reset), .d_in(din0), .buffer_empty(empty[0]),
        .buffer_read(rd[0]), .msb_first(msb), .tx_done(txd), .tx_start(txs[0]),
        .d_out(dout0), .busy(busy[0]), .frame_done(fd[0])
    );

    tx_word_serializer #(.WORD_W(128), .BYTE_W(8)) dut128 (
        .clk(clk), .reset(reset), .d_in(din1), .buffer_empty(empty[1]),
        .buffer_read(rd[1]), .msb_first(msb), .tx_done(txd), .tx_start(txs[1]),
        .d_out(dout1), .busy(busy[1]), .frame_done(fd[1])
    );

    int total = 0;
    int bad = 0;
    logic [127:0] fifo_q[$];
    logic [7:0]   exp_q[$];
    int           frame_q[$];
    int act = 0;
    int dly = 5;
    int bytes_in_frame = 0;
    int rd_count = 0, txs_count = 0, fd_count = 0;
    int edge_n = 0, rd_edge = -100, td_edge = -100;
    bit first_pending = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference model: split the word into bytes in the requested order and append the XOR when enabled.
    task automatic push_word(input logic [127:0] w, input bit m);
        int nb;
        logic [7:0] x;
        logic [7:0] b;
        nb = (act != 0) ? 16 : 4;
        x  = 8'h00;
        for (int i = 0; i < nb; i++) begin
            b = m ? 8'(w >> (8 * (nb - 1 - i))) : 8'(w >> (8 * i));
            exp_q.push_back(b);
            x = x ^ b;
        end
        if (CS != 0) exp_q.push_back(x);
        frame_q.push_back(nb + CS);
        fifo_q.push_back(w);
    endtask

    task automatic clear_counts();
        rd_count = 0; txs_count = 0; fd_count = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(fifo_q.size() == 0 && exp_q.size() == 0 && frame_q.size() == 0 && busy[act] == 1'b0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(n < budget), 128'(1));
        if (n >= budget) begin
            fifo_q.delete(); exp_q.delete(); frame_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Show-ahead FIFO. The head word is visible while not empty and is removed after the buffer_read cycle.
    always @(posedge clk) begin
        logic popped;
        popped = rd[act];
        #1;
        if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
        empty = 2'b11;
        din0  = '0;
        din1  = '0;
        if (fifo_q.size() > 0) begin
            empty[act] = 1'b0;
            if (act == 0) din0 = fifo_q[0][31:0];
            else          din1 = fifo_q[0];
        end
    end

    // UART responder: answers each tx_start with one tx_done pulse dly cycles later.
    always @(negedge clk) begin
        if (txs[act]) begin
            repeat (dly) @(negedge clk);
            txd_resp = 1'b1;
            @(negedge clk);
            txd_resp = 1'b0;
        end
    end

    // Scoreboard monitor: checks bytes, frame length and latency whenever the DUT presents output.
    always @(posedge clk) begin
        logic       td;
        logic [7:0] dv;
        logic [7:0] eb;
        int         ef;
        td = txd;
        edge_n++;
        #1;
        if (td) td_edge = edge_n;
        if (rd[act]) begin
            rd_count++;
            rd_edge = edge_n;
            first_pending = 1'b1;
        end
        if (txs[act]) begin
            txs_count++;
            dv = (act != 0) ? dout1 : dout0;
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("tx_byte", 128'(dv), 128'(eb));
            if (first_pending) begin
                chk("first_tx_start_latency", 128'(edge_n - rd_edge), 128'(2));
                first_pending = 1'b0;
            end else begin
                chk("tx_start_after_tx_done", 128'(edge_n - td_edge), 128'(1));
            end
            bytes_in_frame++;
        end
        if (fd[act]) begin
            fd_count++;
            ef = (frame_q.size() > 0) ? frame_q.pop_front() : -1;
            chk("frame_len", 128'(bytes_in_frame), 128'(ef));
            chk("frame_done_latency", 128'(edge_n - td_edge), 128'(0));
            chk("frame_done_with_tx_start", 128'(txs[act]), 128'(0));
            bytes_in_frame = 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        logic [127:0] w;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_buffer_read", 128'(rd), 128'(0));
        chk("rst_tx_start", 128'(txs), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_frame_done", 128'(fd), 128'(0));
        chk("rst_d_out32", 128'(dout0), 128'(0));
        chk("rst_d_out128", 128'(dout1), 128'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 32-bit word, MSB first, slow UART
        act = 0; msb = 1'b1; dly = 5; clear_counts();
        push_word(128'h A1B2C3D4, 1'b1);
        wait_idle(400, "t1_finish");
        chk("t1_buffer_read_count", 128'(rd_count), 128'(1));
        chk("t1_tx_start_count", 128'(txs_count), 128'(4 + CS));
        chk("t1_frame_done_count", 128'(fd_count), 128'(1));

        // LSB first, msb_first toggled mid-word
        msb = 1'b0; clear_counts();
        push_word(128'h A1B2C3D4, 1'b0);
        for (int i = 0; i < 200 && bytes_in_frame < 1; i++) @(negedge clk);
        msb = 1'b1;
        wait_idle(400, "t2_finish");
        chk("t2_tx_start_count", 128'(txs_count), 128'(4 + CS));

        // 128-bit, immediate tx_done, two back-to-back words
        act = 1; msb = 1'b1; dly = 0; clear_counts();
        push_word(128'h00112233445566778899AABBCCDDEEFF, 1'b1);
        push_word({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        wait_idle(600, "t3_finish");
        chk("t3_buffer_read_count", 128'(rd_count), 128'(2));
        chk("t3_tx_start_count", 128'(txs_count), 128'(32 + 2 * CS));
        chk("t3_frame_done_count", 128'(fd_count), 128'(2));

        // Empty FIFO with stray tx_done pulses
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            txd_stim = (i % 3 == 0);
            chk("t4_buffer_read", 128'(rd), 128'(0));
            chk("t4_tx_start", 128'(txs), 128'(0));
            chk("t4_busy", 128'(busy), 128'(0));
        end
        txd_stim = 1'b0;

        // Reset after the 2nd byte of a 32-bit word
        act = 0; msb = 1'b1; dly = 3; clear_counts();
        repeat (2) @(negedge clk);
        push_word(128'h 11223344, 1'b1);
        for (int i = 0; i < 200 && bytes_in_frame < 2; i++) @(negedge clk);
        chk("t5_reached_2nd_byte", 128'(bytes_in_frame), 128'(2));
        reset = 1'b1;
        exp_q.delete(); frame_q.delete();
        bytes_in_frame = 0; first_pending = 1'b0;
        @(posedge clk);
        #2;
        chk("t5_buffer_read", 128'(rd), 128'(0));
        chk("t5_tx_start", 128'(txs), 128'(0));
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_frame_done", 128'(fd), 128'(0));
        chk("t5_d_out", 128'(dout0), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_no_frame_done", 128'(fd_count), 128'(0));
        push_word(128'h 55667788, 1'b1);
        wait_idle(400, "t5_finish");
        chk("t5_frame_done_count", 128'(fd_count), 128'(1));

        // Word whose checksum is non-zero
        clear_counts();
        push_word(128'h 01020304, 1'b1);
        wait_idle(400, "t6_finish");
        chk("t6_tx_start_count", 128'(txs_count), 128'(4 + CS));

        // Randomized groups
        for (int g = 0; g < 25; g++) begin
            act = $urandom_range(0, 1);
            msb = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 4);
            ng  = $urandom_range(1, 3);
            clear_counts();
            repeat (2) @(negedge clk);
            for (int k = 0; k < ng; k++) begin
                w = {$urandom, $urandom, $urandom, $urandom};
                if (act == 0) w = {96'b0, w[31:0]};
                push_word(w, msb);
            end
            wait_idle(3000, "rand_finish");
            chk("rand_buffer_read_count", 128'(rd_count), 128'(ng));
            chk("rand_frame_done_count", 128'(fd_count), 128'(ng));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
